// File: rtl/ahblite_isp_pkg.sv
// Shared constants for the ISP register file: register map, AHB encodings,
// CTRL bit positions, error-response FSM states and a byte-lane helper.
package ahblite_isp_pkg;

    localparam int unsigned OFF_CTRL   = 32'h00;
    localparam int unsigned OFF_STATUS = 32'h04;
    localparam int unsigned OFF_SPLIT  = 32'h08;
    localparam int unsigned OFF_CFG0   = 32'h0C;

    localparam int unsigned IDX_CTRL   = OFF_CTRL / 4;
    localparam int unsigned IDX_STATUS = OFF_STATUS / 4;
    localparam int unsigned IDX_SPLIT  = OFF_SPLIT / 4;
    localparam int unsigned IDX_CFG0   = OFF_CFG0 / 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_COMMIT_BIT = 1;

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_e;

    // Byte lanes touched by an access of the given size at address a.
    function automatic logic [3:0] lane_be(
        input logic [2:0] size,
        input logic [1:0] a
    );
        case (size)
            HSIZE_BYTE: lane_be = 4'b0001 << a;
            HSIZE_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahblite_isp_shadow_reg.sv
// One 32-bit shadow/active register pair. Ports: HCLK, HRESET (sync, high),
// be/wdata write the shadow per byte lane, commit copies shadow to active.
module ahblite_isp_shadow_reg (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic        commit,
    output logic [31:0] shadow_q,
    output logic [31:0] active_q
);

    // Active samples the old shadow, so a write on the commit edge
    // lands in the shadow only and waits for the next commit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (commit) begin
                active_q <= shadow_q;
            end
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    shadow_q[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahblite_isp_regfile.sv
// AHB-Lite register file for the ISP: CTRL, STATUS, shadowed SPLIT and CFG.
// Ports: AHB-Lite subordinate bus, frame_start, isp_ctrl_en, split_x/y, cfg_data.
module ahblite_isp_regfile
    import ahblite_isp_pkg::*;
#(
    parameter int NUM_CFG = 4,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    input  logic [3:0]             HPROT,
    input  logic                   HWRITE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic [31:0]            HRDATA,
    output logic                   HRESP,
    input  logic                   frame_start,
    output logic                   isp_ctrl_en,
    output logic [COORD_W-1:0]     split_x,
    output logic [COORD_W-1:0]     split_y,
    output logic [NUM_CFG*32-1:0]  cfg_data
);

    localparam int NREG      = NUM_CFG + 1;
    localparam int MAP_BYTES = 4 * (3 + NUM_CFG);
    localparam int AW2       = ADDR_W - 2;
    localparam int SPLIT_W   = 2 * COORD_W;
    localparam logic [31:0] SPLIT_MASK =
        32'((64'd1 << SPLIT_W) - 64'd1);

    // Address phase decode
    logic              a_acc;
    logic              a_err;
    logic [ADDR_W-1:0] a_off;

    assign a_off = HADDR[ADDR_W-1:0];
    assign a_acc = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        a_err = 1'b0;
        if ({1'b0, a_off} >= (ADDR_W+1)'(MAP_BYTES)) begin
            a_err = 1'b1;
        end
        if (HWRITE && (a_off[ADDR_W-1:2] == AW2'(IDX_STATUS))) begin
            a_err = 1'b1;
        end
        if (HSIZE > HSIZE_WORD) begin
            a_err = 1'b1;
        end
        if ((HSIZE == HSIZE_HALF) && a_off[0]) begin
            a_err = 1'b1;
        end
        if ((HSIZE == HSIZE_WORD) && (a_off[1:0] != 2'b00)) begin
            a_err = 1'b1;
        end
    end

    // Data phase registers; errored transfers never become valid
    logic              dp_valid;
    logic              dp_write;
    logic [ADDR_W-1:0] dp_off;
    logic [2:0]        dp_size;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= '0;
            dp_size  <= '0;
        end else begin
            dp_valid <= a_acc & ~a_err;
            if (a_acc) begin
                dp_write <= HWRITE;
                dp_off   <= a_off;
                dp_size  <= HSIZE;
            end
        end
    end

    logic [3:0]     dp_be;
    logic           wr;
    logic [AW2-1:0] d_idx;

    assign dp_be = lane_be(dp_size, dp_off[1:0]);
    assign wr    = dp_valid & dp_write;
    assign d_idx = dp_off[ADDR_W-1:2];

    // CTRL, pending flag and frame counter
    logic        en;
    logic        pending;
    logic [15:0] frame_cnt;
    logic        ctrl_wr;
    logic        commit_set;
    logic        copy;

    assign ctrl_wr    = wr & (d_idx == AW2'(IDX_CTRL)) & dp_be[0];
    assign commit_set = ctrl_wr & HWDATA[CTRL_COMMIT_BIT];
    // Uses the flag as it was before this edge, so a commit landing
    // together with frame_start waits for the following frame.
    assign copy       = frame_start & pending;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            en        <= 1'b0;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (ctrl_wr) begin
                en <= HWDATA[CTRL_EN_BIT];
            end
            if (commit_set) begin
                pending <= 1'b1;
            end else if (copy) begin
                pending <= 1'b0;
            end
            if (frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Shadow/active pairs: entry 0 is SPLIT, entry 1+i is CFG[i]
    logic [31:0] sh_q  [NREG];
    logic [31:0] act_q [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_sh
        logic       sel;
        logic [31:0] wd;
        assign sel = wr & (d_idx == AW2'(IDX_SPLIT + k));
        assign wd  = (k == 0) ? (HWDATA & SPLIT_MASK) : HWDATA;

        ahblite_isp_shadow_reg u_reg (
            .HCLK     (HCLK),
            .HRESET   (HRESET),
            .be       (dp_be & {4{sel}}),
            .wdata    (wd),
            .commit   (copy),
            .shadow_q (sh_q[k]),
            .active_q (act_q[k])
        );
    end

    // Read mux, driven only by registered state
    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            if (d_idx == AW2'(IDX_CTRL)) begin
                HRDATA = {30'b0, 1'b0, en};
            end
            if (d_idx == AW2'(IDX_STATUS)) begin
                HRDATA = {frame_cnt, 15'b0, pending};
            end
            for (int k = 0; k < NREG; k++) begin
                if (d_idx == AW2'(IDX_SPLIT + k)) begin
                    HRDATA = sh_q[k];
                end
            end
        end
    end

    // Two-cycle ERROR response
    err_state_e state_q;
    err_state_e state_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= OKAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            OKAY: begin
                if (a_acc && a_err) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                HRESP   = 1'b1;
                state_d = (a_acc && a_err) ? ERR1 : OKAY;
            end
            default: begin
                state_d = OKAY;
            end
        endcase
    end

    // Outputs
    assign isp_ctrl_en = en;
    assign split_x     = act_q[0][SPLIT_W-1:COORD_W];
    assign split_y     = act_q[0][COORD_W-1:0];

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        assign cfg_data[32*i +: 32] = act_q[i+1];
    end

    logic unused;
    assign unused = ^{HPROT, HADDR[31:ADDR_W], HTRANS[0],
                      act_q[0] & ~SPLIT_MASK};

endmodule

// File: tb/tb_ahblite_isp_regfile.sv
// Directed testbench for ahblite_isp_regfile.
// Each task drives one scenario and checks hand-computed values inline.
module tb_ahblite_isp_regfile;

    localparam int NUM_CFG = 4;
    localparam int COORD_W = 11;
    localparam int ADDR_W  = 8;

    logic                  HCLK = 1'b0;
    logic                  HRESET = 1'b1;
    logic                  HSEL = 1'b0;
    logic [31:0]           HADDR = '0;
    logic [1:0]            HTRANS = 2'b00;
    logic [2:0]            HSIZE = 3'd0;
    logic [3:0]            HPROT = 4'd0;
    logic                  HWRITE = 1'b0;
    logic [31:0]           HWDATA = '0;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [31:0]           HRDATA;
    logic                  HRESP;
    logic                  frame_start = 1'b0;
    logic                  isp_ctrl_en;
    logic [COORD_W-1:0]    split_x;
    logic [COORD_W-1:0]    split_y;
    logic [NUM_CFG*32-1:0] cfg_data;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahblite_isp_regfile #(
        .NUM_CFG (NUM_CFG),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSIZE       (HSIZE),
        .HPROT       (HPROT),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HREADYOUT   (HREADYOUT),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .frame_start (frame_start),
        .isp_ctrl_en (isp_ctrl_en),
        .split_x     (split_x),
        .split_y     (split_y),
        .cfg_data    (cfg_data)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic [2:0] sz,
                           input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = a;
        HSIZE  = sz;
        HWRITE = wr;
    endtask

    task automatic idle_ph();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d);
        addr_ph(a, sz, 1'b1);
        tick();
        idle_ph();
        HWDATA = d;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_ph(a, 3'd2, 1'b0);
        tick();
        idle_ph();
        d = HRDATA;
        tick();
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_frames++;
    endtask

    function automatic logic [31:0] status_exp(input logic pend);
        return {16'(exp_frames), 15'b0, pend};
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        HRESET = 1'b1;
        frame_start = 1'b1;
        repeat (2) tick();
        HRESET = 1'b0;
        frame_start = 1'b0;
        checks++;
        if ({isp_ctrl_en, split_x, split_y, cfg_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b x=%h y=%h cfg=%h want all 0",
                     isp_ctrl_en, split_x, split_y, cfg_data);
        end
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_bus: got rdy=%b resp=%b rdata=%h want 1 0 0",
                     HREADYOUT, HRESP, HRDATA);
        end
        bus_read(32'h04, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] d;
        bus_write(32'h00, 3'd2, 32'h0000_0001);
        checks++;
        if (isp_ctrl_en !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_en: got %b want 1", isp_ctrl_en);
        end
        bus_read(32'h00, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL ctrl_read: got %h want %h", d, 32'h1);
        end
    endtask

    task automatic test_split_commit();
        logic [31:0] d;
        bus_write(32'h08, 3'd2, 32'h0014_0064);
        pulse();
        checks++;
        if ({split_x, split_y} !== '0) begin
            errors++;
            $display("FAIL split_nocommit: got x=%h y=%h want 0 0",
                     split_x, split_y);
        end
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h0014_0064) begin
            errors++;
            $display("FAIL split_shadow_read: got %h want %h", d, 32'h0014_0064);
        end
        bus_write(32'h00, 3'd2, 32'h0000_0003);
        bus_read(32'h04, d);
        checks++;
        if (d !== 32'h0001_0001) begin
            errors++;
            $display("FAIL status_pending: got %h want %h", d, 32'h0001_0001);
        end
        pulse();
        checks++;
        if (split_x !== 11'h280 || split_y !== 11'h064) begin
            errors++;
            $display("FAIL split_commit: got x=%h y=%h want 280 064",
                     split_x, split_y);
        end
        bus_read(32'h04, d);
        checks++;
        if (d !== 32'h0002_0000) begin
            errors++;
            $display("FAIL status_cleared: got %h want %h", d, 32'h0002_0000);
        end
    endtask

    task automatic test_cfg_lanes();
        logic [31:0] d;
        bus_write(32'h0C, 3'd2, 32'h1122_3344);
        bus_write(32'h0E, 3'd0, 32'h00AB_0000);
        bus_read(32'h0C, d);
        checks++;
        if (d !== 32'h11AB_3344) begin
            errors++;
            $display("FAIL cfg_byte_shadow: got %h want %h", d, 32'h11AB_3344);
        end
        checks++;
        if (cfg_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL cfg_active_early: got %h want 0", cfg_data[31:0]);
        end
        bus_write(32'h12, 3'd1, 32'hBEEF_0000);
        bus_read(32'h10, d);
        checks++;
        if (d !== 32'hBEEF_0000) begin
            errors++;
            $display("FAIL cfg_half_shadow: got %h want %h", d, 32'hBEEF_0000);
        end
        bus_write(32'h00, 3'd2, 32'h0000_0003);
        pulse();
        checks++;
        if (cfg_data[63:0] !== 64'hBEEF_0000_11AB_3344) begin
            errors++;
            $display("FAIL cfg_commit: got %h want %h", cfg_data[63:0],
                     64'hBEEF_0000_11AB_3344);
        end
    endtask

    localparam logic [31:0] EA [6] = '{32'h20, 32'h02, 32'h04,
                                       32'h00, 32'h0D, 32'h1E};
    localparam logic [2:0]  ES [6] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd1, 3'd2};
    localparam logic        EW [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic test_errors();
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            addr_ph(EA[i], ES[i], EW[i]);
            tick();
            idle_ph();
            HWDATA = 32'hFFFF_FFFF;
            checks++;
            if ({HREADYOUT, HRESP, HRDATA} !== {1'b0, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL err%0d_cycle1: got rdy=%b resp=%b rdata=%h want 0 1 0",
                         i, HREADYOUT, HRESP, HRDATA);
            end
            tick();
            checks++;
            if ({HREADYOUT, HRESP} !== 2'b11) begin
                errors++;
                $display("FAIL err%0d_cycle2: got rdy=%b resp=%b want 1 1",
                         i, HREADYOUT, HRESP);
            end
            tick();
            checks++;
            if ({HREADYOUT, HRESP} !== 2'b10) begin
                errors++;
                $display("FAIL err%0d_after: got rdy=%b resp=%b want 1 0",
                         i, HREADYOUT, HRESP);
            end
        end
        bus_read(32'h04, d);
        checks++;
        if (d !== status_exp(1'b0)) begin
            errors++;
            $display("FAIL err_status: got %h want %h", d, status_exp(1'b0));
        end
        bus_read(32'h0C, d);
        checks++;
        if (d !== 32'h11AB_3344) begin
            errors++;
            $display("FAIL err_cfg0: got %h want %h", d, 32'h11AB_3344);
        end
    endtask

    task automatic test_ignored();
        logic [31:0] d;
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd2; HWRITE = 1'b1;
        tick();
        HTRANS = 2'b01;
        HWDATA = 32'h0;
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++;
            $display("FAIL idle_resp: got rdy=%b resp=%b want 1 0",
                     HREADYOUT, HRESP);
        end
        tick();
        HSEL = 1'b0; HTRANS = 2'b10;
        tick();
        idle_ph();
        tick();
        bus_read(32'h00, d);
        checks++;
        if (d !== 32'h1 || isp_ctrl_en !== 1'b1) begin
            errors++;
            $display("FAIL ignored_writes: got ctrl=%h en=%b want 1 1",
                     d, isp_ctrl_en);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1;
        logic [31:0] d2;
        addr_ph(32'h14, 3'd2, 1'b1);
        tick();
        addr_ph(32'h18, 3'd2, 1'b1);
        HWDATA = 32'hA5A5_0001;
        tick();
        idle_ph();
        HWDATA = 32'h5A5A_0002;
        tick();
        addr_ph(32'h14, 3'd2, 1'b0);
        tick();
        addr_ph(32'h18, 3'd2, 1'b0);
        d1 = HRDATA;
        tick();
        idle_ph();
        d2 = HRDATA;
        tick();
        checks++;
        if (d1 !== 32'hA5A5_0001 || d2 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL b2b: got %h %h want %h %h", d1, d2,
                     32'hA5A5_0001, 32'h5A5A_0002);
        end
    endtask

    task automatic test_commit_race();
        logic [31:0] d;
        bus_write(32'h0C, 3'd2, 32'hCAFE_F00D);
        addr_ph(32'h00, 3'd2, 1'b1);
        tick();
        idle_ph();
        HWDATA = 32'h3;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_frames++;
        checks++;
        if (cfg_data[31:0] !== 32'h11AB_3344) begin
            errors++;
            $display("FAIL race_nocopy: got %h want %h", cfg_data[31:0],
                     32'h11AB_3344);
        end
        bus_read(32'h04, d);
        checks++;
        if (d !== status_exp(1'b1)) begin
            errors++;
            $display("FAIL race_pending: got %h want %h", d, status_exp(1'b1));
        end
        pulse();
        checks++;
        if (cfg_data[31:0] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL race_copy: got %h want %h", cfg_data[31:0],
                     32'hCAFE_F00D);
        end
        bus_read(32'h04, d);
        checks++;
        if (d !== status_exp(1'b0)) begin
            errors++;
            $display("FAIL race_cleared: got %h want %h", d, status_exp(1'b0));
        end
    endtask

    task automatic test_shadow_race();
        logic [31:0] d;
        bus_write(32'h10, 3'd2, 32'h0000_AAAA);
        bus_write(32'h00, 3'd2, 32'h0000_0003);
        addr_ph(32'h10, 3'd2, 1'b1);
        tick();
        idle_ph();
        HWDATA = 32'h1234_5678;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_frames++;
        checks++;
        if (cfg_data[63:32] !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL shrace_active: got %h want %h", cfg_data[63:32],
                     32'h0000_AAAA);
        end
        bus_read(32'h10, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL shrace_shadow: got %h want %h", d, 32'h1234_5678);
        end
    endtask

    task automatic test_frame_wrap();
        logic [31:0] d;
        int n;
        n = 32'h1_0000 - exp_frames - 1;
        frame_start = 1'b1;
        repeat (n) tick();
        frame_start = 1'b0;
        exp_frames += n;
        bus_read(32'h04, d);
        checks++;
        if (d[31:16] !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_max: got %h want %h", d[31:16], 16'hFFFF);
        end
        pulse();
        bus_read(32'h04, d);
        checks++;
        if (d[31:16] !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want %h", d[31:16], 16'h0000);
        end
    endtask

    task automatic test_reset_mid_err();
        logic [31:0] d;
        addr_ph(32'h20, 3'd2, 1'b0);
        tick();
        idle_ph();
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b01) begin
            errors++;
            $display("FAIL rst_err_cycle1: got rdy=%b resp=%b want 0 1",
                     HREADYOUT, HRESP);
        end
        HRESET = 1'b1;
        tick();
        checks++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            errors++;
            $display("FAIL rst_err_abort: got rdy=%b resp=%b want 1 0",
                     HREADYOUT, HRESP);
        end
        HRESET = 1'b0;
        exp_frames = 0;
        checks++;
        if ({isp_ctrl_en, split_x, split_y, cfg_data} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got en=%b x=%h y=%h cfg=%h want all 0",
                     isp_ctrl_en, split_x, split_y, cfg_data);
        end
        bus_read(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_shadow: got %h want 0", d);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ctrl();
        test_split_commit();
        test_cfg_lanes();
        test_errors();
        test_ignored();
        test_back_to_back();
        test_commit_race();
        test_shadow_race();
        test_frame_wrap();
        test_reset_mid_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_isp_regfile.md
AHBLITE_ISP_REGFILE -- requirements
Module: ahblite_isp_regfile

Interface
REQ-001 SHALL have parameter NUM_CFG, default 4: number of shadowed 32-bit coefficient registers CFG[i], range 1..16.
REQ-002 SHALL have parameter COORD_W, default 11: width of each split coordinate, range 8..16.
REQ-003 SHALL have parameter ADDR_W, default 8: decoded byte-offset width, HADDR[ADDR_W-1:0]; 2^ADDR_W >= 4*(3+NUM_CFG).
REQ-004 HCLK  in  1  sole clock, rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  in  AHB-Lite subordinate inputs; HPROT is ignored.
REQ-007 HREADYOUT  out  1; HRDATA  out  32; HRESP  out  1: AHB-Lite subordinate outputs.
REQ-008 frame_start  in  1  single-cycle pulse from the video timing block, marking the frame boundary.
REQ-009 isp_ctrl_en  out  1  ISP enable, live and not shadowed.
REQ-010 split_x, split_y  out  COORD_W each  active split coordinates.
REQ-011 cfg_data  out  NUM_CFG*32  active CFG registers, CFG[i] at bits [32*i+31:32*i].

Function
REQ-012 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY; offset, HSIZE and HWRITE SHALL be registered for the data phase.
REQ-013 Map: 0x00 CTRL (bit0 en RW, bit1 commit W1S, self-clearing, reads 0); 0x04 STATUS RO; 0x08 SPLIT {x at [2*COORD_W-1:COORD_W], y at [COORD_W-1:0]}; 0x0C+4*i CFG[i].
REQ-014 Writes SHALL honour HSIZE byte/halfword/word lanes selected by HADDR[1:0]; lanes not selected are unchanged.
REQ-015 Write data SHALL be taken from HWDATA in the data phase and updated on the clock edge that ends that data phase.
REQ-016 SPLIT and CFG writes SHALL land in shadow copies; outputs SHALL reflect active copies only.
REQ-017 A write of 1 to CTRL bit1 SHALL set a pending flag; on frame_start with the flag set, all shadows SHALL copy to active and the flag SHALL clear, in the same edge.
REQ-018 If the pending flag sets and frame_start arrive on the same edge, the flag SHALL be 1 afterwards and no copy occurs; the commit applies at the next frame_start.
REQ-019 If a shadow write and a commit occur on the same edge, active SHALL take the pre-write shadow value and the shadow SHALL take the new value.
REQ-020 STATUS SHALL read {frame_cnt[15:0], 15'b0, pending}; frame_cnt SHALL increment on every frame_start and wrap from 0xFFFF to 0.
REQ-021 Reads SHALL return data in the data phase, combinationally from the registered offset; SPLIT and CFG reads SHALL return shadow values, and CTRL reads SHALL return {30'b0, 1'b0, en}.
REQ-022 The following SHALL give an ERROR response, with no state change: an offset >= 4*(3+NUM_CFG); a write to STATUS; HSIZE > 2; a misaligned access (halfword with HADDR[0]=1, or word with HADDR[1:0]!=0).
REQ-023 ERROR SHALL be two cycles: cycle 1 HREADYOUT=0 and HRESP=1; cycle 2 HREADYOUT=1 and HRESP=1. Otherwise HREADYOUT=1 and HRESP=0, with zero wait states.
REQ-024 IDLE/BUSY transfers and HSEL=0 SHALL be ignored and return an OKAY response.
REQ-025 HRDATA SHALL be 0 in non-read data phases.

Reset
REQ-026 On HRESET, the following SHALL clear to 0: en, pending, frame_cnt, all shadow and active registers, the data-phase registers and the error state; outputs SHALL be 0 on the cycle after reset.
REQ-027 A reset asserted during a data phase or during an ERROR response SHALL abort it; HREADYOUT=1 and HRESP=0 on the next cycle.
REQ-028 A frame_start during reset SHALL be ignored.

Structure
REQ-029 Package ahblite_isp_pkg SHALL hold the register offset constants, the HTRANS/HSIZE encodings, the CTRL bit positions and the error-FSM state encoding (OKAY, ERR1, ERR2).
REQ-030 Sub-module ahblite_isp_shadow_reg SHALL implement one 32-bit shadow/active pair with byte-lane write enables and a commit input; it SHALL be instantiated NUM_CFG+1 times.
REQ-031 The implementation SHALL have no latches and no combinational path from HWDATA to any output.

Verification
REQ-032 Word write 0x0000_0001 to 0x00 -> isp_ctrl_en=1 on the following cycle; read 0x00 returns 0x0000_0001.
REQ-033 Write SPLIT=0x0014_0064 (COORD_W=11), no commit, then frame_start -> split_x/y stay 0; write CTRL=0x3, then frame_start -> split_x=0x280, split_y=0x064.
REQ-034 Byte write 0xAB to 0x0E (CFG[0] byte 2) over CFG[0] shadow=0x1122_3344, then commit -> cfg_data[31:0]=0x11AB_3344.
REQ-035 Read 0x20 with NUM_CFG=4 -> HREADYOUT 0 then 1, HRESP 1 for two cycles, no register change; a word write to 0x02 gives the same ERROR response.
REQ-036 CTRL commit write whose data phase ends on the frame_start edge -> pending=1, no copy; the next frame_start copies shadows to active and STATUS bit0 reads 0.
REQ-037 Issue 0x10000 frame_start pulses -> STATUS[31:16] wraps to 0x0000; HRESET asserted mid-ERROR -> HRESP=0 on the next cycle.
